// File: rtl/timer_pkg.sv
// Shared constants and types for the timer APB register block:
// register addresses, TCR/TSR bit positions and the bus FSM states.
package timer_pkg;

    localparam int ADDR_TDR  = 0;
    localparam int ADDR_TCR  = 1;
    localparam int ADDR_TSR  = 2;
    localparam int ADDR_TCNT = 3;

    localparam int TCR_LOAD    = 7;
    localparam int TCR_UPDOWN  = 5;
    localparam int TCR_EN      = 4;
    localparam int TCR_CKS_MSB = 1;
    localparam int TCR_CKS_LSB = 0;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    // Reserved TCR bits 6, 3 and 2 are never stored.
    localparam logic [7:0] TCR_MASK = 8'hB3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the CPU interconnect (master) and the timer
// register block (slave).
interface timer_apb_regs_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_fsm.sv
// APB transfer sequencer: tracks setup/access phases, inserts the
// configured wait states and produces pready plus read/write strobes.
module timer_apb_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    output logic pready,
    output logic wr_stb,
    output logic rd_stb
);

    apb_state_e state;
    logic [2:0] wait_cnt;

    // SETUP is the cycle right after a completion; a new setup phase seen
    // there (or in IDLE) moves straight to ACCESS so back-to-back transfers
    // need no idle bubble.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE, SETUP: begin
                    if (psel && !penable) begin
                        state    <= ACCESS;
                        wait_cnt <= 3'(WAIT_STATES);
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!(psel && penable)) begin
                        state <= IDLE;
                    end else if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        state <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pready = (state == ACCESS) && psel && penable && (wait_cnt == 3'd0);
    assign wr_stb = pready && pwrite;
    assign rd_stb = pready && !pwrite;

endmodule

// File: rtl/timer_apb_regs.sv
// Timer register file behind an APB slave port: TDR, TCR, sticky TSR
// flags and a read-only counter snapshot, driving the counter core controls.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic                pclk,
    input  logic                presetn,
    timer_apb_regs_if.slave     apb,
    input  logic [7:0]          cnt_val,
    input  logic                ovf_pulse,
    input  logic                udf_pulse,
    output logic [7:0]          tdr,
    output logic                load,
    output logic                updown,
    output logic                en,
    output logic [1:0]          cks
);

    logic       pready;
    logic       wr_stb;
    logic       rd_stb;
    logic       addr_err;
    logic       wr_ok;
    logic       tsr_clr_ovf;
    logic       tsr_clr_udf;
    logic [7:0] tcr;
    logic       ovf_flag;
    logic       udf_flag;
    logic [7:0] rd_val;

    timer_apb_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (apb.psel),
        .penable (apb.penable),
        .pwrite  (apb.pwrite),
        .pready  (pready),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb)
    );

    assign addr_err = (apb.paddr > ADDR_W'(ADDR_TCNT)) ||
                      (apb.pwrite && (apb.paddr == ADDR_W'(ADDR_TCNT)));
    assign wr_ok    = wr_stb && !addr_err;

    assign tsr_clr_ovf = wr_ok && (apb.paddr == ADDR_W'(ADDR_TSR)) && !apb.pwdata[TSR_OVF];
    assign tsr_clr_udf = wr_ok && (apb.paddr == ADDR_W'(ADDR_TSR)) && !apb.pwdata[TSR_UDF];

    // Hardware events are OR-ed in after the software clear, so a set in
    // the same cycle as a clear leaves the flag high.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr      <= 8'h00;
            tcr      <= 8'h00;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (wr_ok && (apb.paddr == ADDR_W'(ADDR_TDR))) begin
                tdr <= apb.pwdata;
            end
            if (wr_ok && (apb.paddr == ADDR_W'(ADDR_TCR))) begin
                tcr <= apb.pwdata & TCR_MASK;
            end
            ovf_flag <= ovf_pulse || (ovf_flag && !tsr_clr_ovf);
            udf_flag <= udf_pulse || (udf_flag && !tsr_clr_udf);
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (apb.paddr)
            ADDR_W'(ADDR_TDR):  rd_val = tdr;
            ADDR_W'(ADDR_TCR):  rd_val = tcr;
            ADDR_W'(ADDR_TSR):  rd_val = {6'b0, udf_flag, ovf_flag};
            ADDR_W'(ADDR_TCNT): rd_val = cnt_val;
            default:            rd_val = 8'h00;
        endcase
    end

    assign apb.prdata  = (rd_stb && !addr_err) ? rd_val : 8'h00;
    assign apb.pready  = pready;
    assign apb.pslverr = pready && addr_err;

    assign load   = tcr[TCR_LOAD];
    assign updown = tcr[TCR_UPDOWN];
    assign en     = tcr[TCR_EN];
    assign cks    = tcr[TCR_CKS_MSB:TCR_CKS_LSB];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: three builds (0, 2 and 3 wait
// states) checked against a register-level reference model.
module tb_timer_apb_regs;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = 8'h00, pwdata = 8'h00;
    logic [7:0] cnt_val = 8'h00;
    logic       ovf_pulse = 1'b0, udf_pulse = 1'b0;

    int which = 0;
    int errors = 0;
    int checks = 0;

    logic [7:0] m_tdr, m_tcr;
    logic       m_ovf, m_udf;

    logic [7:0] tdr0, tdr2, tdr3;
    logic       load0, load2, load3, updown0, updown2, updown3, en0, en2, en3;
    logic [1:0] cks0, cks2, cks3;

    logic [7:0] prdata_o, tdr_o;
    logic       pready_o, pslverr_o, load_o, updown_o, en_o;
    logic [1:0] cks_o;

    always #5 pclk = ~pclk;

    timer_apb_regs_if #(.ADDR_W(8)) bus0 ();
    timer_apb_regs_if #(.ADDR_W(8)) bus2 ();
    timer_apb_regs_if #(.ADDR_W(8)) bus3 ();

    assign bus0.psel = psel; assign bus0.penable = penable; assign bus0.pwrite = pwrite;
    assign bus0.paddr = paddr; assign bus0.pwdata = pwdata;
    assign bus2.psel = psel; assign bus2.penable = penable; assign bus2.pwrite = pwrite;
    assign bus2.paddr = paddr; assign bus2.pwdata = pwdata;
    assign bus3.psel = psel; assign bus3.penable = penable; assign bus3.pwrite = pwrite;
    assign bus3.paddr = paddr; assign bus3.pwdata = pwdata;

    timer_apb_regs #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
        .pclk(pclk), .presetn(presetn), .apb(bus0), .cnt_val(cnt_val),
        .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse), .tdr(tdr0),
        .load(load0), .updown(updown0), .en(en0), .cks(cks0));

    timer_apb_regs #(.WAIT_STATES(2), .ADDR_W(8)) dut2 (
        .pclk(pclk), .presetn(presetn), .apb(bus2), .cnt_val(cnt_val),
        .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse), .tdr(tdr2),
        .load(load2), .updown(updown2), .en(en2), .cks(cks2));

    timer_apb_regs #(.WAIT_STATES(3), .ADDR_W(8)) dut3 (
        .pclk(pclk), .presetn(presetn), .apb(bus3), .cnt_val(cnt_val),
        .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse), .tdr(tdr3),
        .load(load3), .updown(updown3), .en(en3), .cks(cks3));

    always_comb begin
        prdata_o = bus0.prdata; pready_o = bus0.pready; pslverr_o = bus0.pslverr;
        tdr_o = tdr0; load_o = load0; updown_o = updown0; en_o = en0; cks_o = cks0;
        if (which == 2) begin
            prdata_o = bus2.prdata; pready_o = bus2.pready; pslverr_o = bus2.pslverr;
            tdr_o = tdr2; load_o = load2; updown_o = updown2; en_o = en2; cks_o = cks2;
        end else if (which == 3) begin
            prdata_o = bus3.prdata; pready_o = bus3.pready; pslverr_o = bus3.pslverr;
            tdr_o = tdr3; load_o = load3; updown_o = updown3; en_o = en3; cks_o = cks3;
        end
    end

    // Reference model of the programmer-visible register map
    function automatic logic [7:0] model_read(input logic [7:0] addr);
        case (addr)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr & 8'hB3;
            8'h02:   return {6'b0, m_udf, m_ovf};
            8'h03:   return cnt_val;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_err(input logic wr, input logic [7:0] addr);
        return (addr > 8'h03) || (wr && addr == 8'h03);
    endfunction

    function automatic void model_commit(input logic wr, input logic [7:0] addr,
                                         input logic [7:0] data, input logic ov, input logic ud);
        if (wr && !model_err(wr, addr)) begin
            if (addr == 8'h00) m_tdr = data;
            if (addr == 8'h01) m_tcr = data;
            if (addr == 8'h02) begin
                m_ovf = m_ovf & data[0];
                m_udf = m_udf & data[1];
            end
        end
        m_ovf = m_ovf | ov;
        m_udf = m_udf | ud;
    endfunction

    task automatic model_clear();
        m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0;
        presetn = 1'b0;
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        model_clear();
    endtask

    // One complete APB transfer; ov/ud are raised during the completion cycle
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            input logic ov, input logic ud,
                            output logic [7:0] rdata, output logic err, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1; #1;
        waits = 0;
        while (pready_o !== 1'b1 && waits <= 20) begin
            @(posedge pclk); #1;
            waits++;
        end
        checks++;
        if (pready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pready_timeout addr=%h: got pready=%b, required 1", addr, pready_o);
        end
        rdata = prdata_o; err = pslverr_o;
        ovf_pulse = ov; udf_pulse = ud;
        @(posedge pclk); #1;
        ovf_pulse = 1'b0; udf_pulse = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic er; int w;
        presetn = 1'b0;
        @(posedge pclk); @(posedge pclk); #1;
        checks++;
        if ({pready_o, pslverr_o, prdata_o} !== 10'h000) begin
            errors++; $display("[TB] FAIL reset_bus: got %b/%b/%h, required 0/0/00", pready_o, pslverr_o, prdata_o);
        end
        checks++;
        if ({tdr_o, load_o, updown_o, en_o, cks_o} !== 13'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: got tdr=%h ctl=%b%b%b%b, required 0", tdr_o, load_o, updown_o, en_o, cks_o);
        end
        presetn = 1'b1;
        model_clear();
        cnt_val = 8'($urandom);
        for (int a = 0; a < 4; a++) begin
            apb_xfer(1'b0, 8'(a), 8'h00, 1'b0, 1'b0, rd, er, w);
            checks++;
            if (rd !== ((a == 3) ? cnt_val : 8'h00) || er !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_read a=%0d: got %h err=%b, required %h err=0", a, rd, er, (a == 3) ? cnt_val : 8'h00);
            end
        end
    endtask

    task automatic test_registers();
        logic [7:0] rd; logic er; int w;
        apb_xfer(1'b1, 8'h00, 8'h64, 1'b0, 1'b0, rd, er, w);
        apb_xfer(1'b1, 8'h01, 8'h80, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (tdr_o !== 8'h64 || load_o !== 1'b1) begin
            errors++; $display("[TB] FAIL tdr_load: got tdr=%h load=%b, required 64 1", tdr_o, load_o);
        end
        apb_xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h80) begin errors++; $display("[TB] FAIL tcr_read80: got %h, required 80", rd); end
        apb_xfer(1'b1, 8'h01, 8'h11, 1'b0, 1'b0, rd, er, w);
        checks++;
        if ({load_o, updown_o, en_o, cks_o} !== 5'b00101) begin
            errors++; $display("[TB] FAIL tcr_ctl11: got %b%b%b%b, required 0 0 1 01", load_o, updown_o, en_o, cks_o);
        end
        apb_xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h11) begin errors++; $display("[TB] FAIL tcr_read11: got %h, required 11", rd); end
        apb_xfer(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, rd, er, w);
        apb_xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'hB3) begin errors++; $display("[TB] FAIL tcr_reserved: got %h, required b3", rd); end
    endtask

    task automatic test_flags();
        logic [7:0] rd; logic er; int w;
        do_reset();
        ovf_pulse = 1'b1; @(posedge pclk); #1; ovf_pulse = 1'b0;
        apb_xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("[TB] FAIL tsr_ovf_set: got %h, required 01", rd); end
        apb_xfer(1'b1, 8'h02, 8'h00, 1'b0, 1'b0, rd, er, w);
        apb_xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("[TB] FAIL tsr_clear: got %h, required 00", rd); end
        apb_xfer(1'b1, 8'h02, 8'h00, 1'b0, 1'b1, rd, er, w);
        apb_xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("[TB] FAIL tsr_set_wins: got %h, required 02", rd); end
        apb_xfer(1'b1, 8'h02, 8'h03, 1'b0, 1'b0, rd, er, w);
        apb_xfer(1'b0, 8'h02, 8'h00, 1'b1, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("[TB] FAIL tsr_write1_keep_presample: got %h, required 02", rd); end
        apb_xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h03) begin errors++; $display("[TB] FAIL tsr_both: got %h, required 03", rd); end
    endtask

    task automatic test_errors();
        logic [7:0] rd; logic er; int w;
        do_reset();
        apb_xfer(1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, rd, er, w);
        apb_xfer(1'b0, 8'h05, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (er !== 1'b1 || rd !== 8'h00) begin errors++; $display("[TB] FAIL err_read05: got err=%b data=%h, required 1 00", er, rd); end
        apb_xfer(1'b1, 8'h03, 8'hC3, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (er !== 1'b1) begin errors++; $display("[TB] FAIL err_write_tcnt: got err=%b, required 1", er); end
        apb_xfer(1'b1, 8'h80, 8'hC3, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (er !== 1'b1 || tdr_o !== 8'h5A) begin errors++; $display("[TB] FAIL err_write80: got err=%b tdr=%h, required 1 5a", er, tdr_o); end
        apb_xfer(1'b1, 8'h81, 8'hFF, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (er !== 1'b1 || {load_o, updown_o, en_o, cks_o} !== 5'b0) begin
            errors++; $display("[TB] FAIL err_no_alias_tcr: got err=%b ctl=%b%b%b%b, required 1 0", er, load_o, updown_o, en_o, cks_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, addr, data, exp_rd; logic er, wr, ov, ud, exp_err; int w;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            cnt_val = 8'($urandom);
            ov = ($urandom_range(0, 3) == 0);
            ud = ($urandom_range(0, 3) == 0);
            exp_err = model_err(wr, addr);
            exp_rd = (wr || exp_err) ? 8'h00 : model_read(addr);
            apb_xfer(wr, addr, data, ov, ud, rd, er, w);
            model_commit(wr, addr, data, ov, ud);
            checks++;
            if (rd !== exp_rd || er !== exp_err || w != 0) begin
                errors++; $display("[TB] FAIL rand_xfer i=%0d wr=%b addr=%h: got data=%h err=%b waits=%0d, required %h %b 0", i, wr, addr, rd, er, w, exp_rd, exp_err);
            end
            checks++;
            if (tdr_o !== m_tdr || {load_o, updown_o, en_o, cks_o} !== {m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]}) begin
                errors++; $display("[TB] FAIL rand_outputs i=%0d: got tdr=%h tcr_ctl=%b%b%b%b, required tdr=%h tcr=%h", i, tdr_o, load_o, updown_o, en_o, cks_o, m_tdr, m_tcr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic er; int w; logic exp_rdy;
        which = 3;
        do_reset();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h3C;
        @(posedge pclk); #1;
        penable = 1'b1; #1;
        for (int c = 1; c <= 4; c++) begin
            exp_rdy = (c == 4);
            checks++;
            if (pready_o !== exp_rdy || tdr_o !== 8'h00) begin
                errors++; $display("[TB] FAIL wait_cycle c=%0d: got pready=%b tdr=%h, required %b 00", c, pready_o, tdr_o, exp_rdy);
            end
            if (c < 4) begin @(posedge pclk); #1; end
        end
        @(posedge pclk); #1;
        checks++;
        if (tdr_o !== 8'h3C) begin errors++; $display("[TB] FAIL wait_commit: got tdr=%h, required 3c", tdr_o); end
        apb_xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h3C || w != 3 || er !== 1'b0) begin
            errors++; $display("[TB] FAIL back_to_back: got data=%h waits=%0d err=%b, required 3c 3 0", rd, w, er);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] rd; logic er; int w;
        which = 2;
        do_reset();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAB;
        @(posedge pclk); #1;
        penable = 1'b1; #1;
        checks++;
        if (pready_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wait: got pready=%b, required 0", pready_o); end
        presetn = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (pready_o !== 1'b0 || tdr_o !== 8'h00) begin
            errors++; $display("[TB] FAIL midrst_after: got pready=%b tdr=%h, required 0 00", pready_o, tdr_o);
        end
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, rd, er, w);
        checks++;
        if (rd !== 8'h00 || tdr_o !== 8'h00) begin errors++; $display("[TB] FAIL midrst_tdr: got read=%h tdr=%h, required 00", rd, tdr_o); end
    endtask

    initial begin
        model_clear();
        which = 0;
        test_reset();
        test_registers();
        test_flags();
        test_errors();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
